// File: rtl/urv_writeback_pkg.sv
// Shared definitions for the writeback stage: FSM state encodings and load funct3 codes.
package urv_writeback_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ALU       = 2'd1,
    ST_LOAD_WAIT = 2'd2
  } wb_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/urv_load_align.sv
// Load data extraction: picks the addressed byte/halfword and sign- or zero-extends it.
module urv_load_align
  import urv_writeback_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lsb,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_byte   = i_data[7:0];
    w_half   = i_lsb[1] ? i_data[31:16] : i_data[15:0];
    o_result = i_data;

    case (i_lsb)
      2'd1:    w_byte = i_data[15:8];
      2'd2:    w_byte = i_data[23:16];
      2'd3:    w_byte = i_data[31:24];
      default: w_byte = i_data[7:0];
    endcase

    case (i_funct3)
      F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_result = {24'h0, w_byte};
      F3_LH:   o_result = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_result = {16'h0, w_half};
      default: o_result = i_data;
    endcase
  end

endmodule

// File: rtl/urv_writeback.sv
// Writeback stage: holds one retiring instruction, waits for load data and drives the
// register-file write port plus the forwarding (bypass) port.
module urv_writeback
  import urv_writeback_pkg::*;
#(
  parameter bit G_BYPASS_LOADS = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic [4:0]  x_rd_i,
  input  logic        x_rd_write_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_load_i,
  input  logic [2:0]  x_funct3_i,
  input  logic [1:0]  x_addr_lsb_i,
  input  logic [31:0] dm_data_i,
  input  logic        dm_load_done_i,
  output logic        w_stall_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_store_o,
  output logic        bypass_rd_write_o,
  output logic [31:0] bypass_rd_value_o
);

  wb_state_t   r_state;
  wb_state_t   w_next_state;
  logic [4:0]  r_rd;
  logic        r_rd_write;
  logic [31:0] r_value;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lsb;
  logic [31:0] w_load_value;
  logic        w_stall;

  urv_load_align u_load_align (
    .i_data   (dm_data_i),
    .i_funct3 (r_funct3),
    .i_lsb    (r_lsb),
    .o_result (w_load_value)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= ST_IDLE;
      r_rd       <= '0;
      r_rd_write <= 1'b0;
      r_value    <= '0;
      r_funct3   <= '0;
      r_lsb      <= '0;
    end else begin
      r_state <= w_next_state;
      if (!w_stall && x_valid_i) begin
        r_rd       <= x_rd_i;
        r_rd_write <= x_rd_write_i;
        r_value    <= x_rd_value_i;
        r_funct3   <= x_funct3_i;
        r_lsb      <= x_addr_lsb_i;
      end
    end
  end

  always_comb begin
    w_stall           = (r_state == ST_LOAD_WAIT) && !dm_load_done_i;
    w_next_state      = r_state;
    rf_rd_store_o     = 1'b0;
    bypass_rd_write_o = 1'b0;
    rf_rd_value_o     = r_value;

    if (!w_stall)
      w_next_state = x_valid_i ? (x_load_i ? ST_LOAD_WAIT : ST_ALU) : ST_IDLE;

    case (r_state)
      ST_ALU: begin
        rf_rd_store_o     = r_rd_write && (r_rd != 5'd0);
        bypass_rd_write_o = rf_rd_store_o;
      end
      ST_LOAD_WAIT: begin
        rf_rd_value_o = w_load_value;
        if (dm_load_done_i) begin
          rf_rd_store_o     = (r_rd != 5'd0);
          bypass_rd_write_o = G_BYPASS_LOADS && rf_rd_store_o;
        end
      end
      default: ;
    endcase
  end

  assign w_stall_o         = w_stall;
  assign rf_rd_o           = r_rd;
  assign bypass_rd_value_o = rf_rd_value_o;

endmodule
